// File: rtl/v2f_seq_udiv32.sv
// Multi-cycle unsigned 32-bit divider/modulo unit using a restoring radix-2 datapath.
// It resolves STEPS_PER_CYCLE quotient bits per clock and uses a valid/ready handshake on each side.
module v2f_seq_udiv32 #(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic        pos_clk,
    input  logic        pos_arst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_by_zero
);

    localparam int ITERS = 32 / STEPS_PER_CYCLE;

    generate
        if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 ||
              STEPS_PER_CYCLE == 4 || STEPS_PER_CYCLE == 8)) begin : g_bad_steps
            $error("v2f_seq_udiv32: STEPS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] qsh_q, qsh_d;
    logic [31:0] dvs_q, dvs_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic        dbz_q, dbz_d;

    logic [31:0] step_acc;
    logic [31:0] step_qsh;

    // Unrolled restoring steps. The shifted-out remainder bit is kept as bit 32 of the
    // minuend, so trial bit 32 is an exact borrow even when the divisor is 2^31 or larger.
    genvar gi;
    generate
        for (gi = 0; gi < STEPS_PER_CYCLE; gi++) begin : g_step
            logic [31:0] acc_in;
            logic [31:0] qsh_in;
            logic [32:0] trial;
            logic [31:0] acc_out;
            logic [31:0] qsh_out;

            if (gi == 0) begin : g_first
                assign acc_in = acc_q;
                assign qsh_in = qsh_q;
            end else begin : g_chain
                assign acc_in = g_step[gi-1].acc_out;
                assign qsh_in = g_step[gi-1].qsh_out;
            end

            assign trial   = {acc_in, qsh_in[31]} - {1'b0, dvs_q};
            assign acc_out = trial[32] ? {acc_in[30:0], qsh_in[31]} : trial[31:0];
            assign qsh_out = {qsh_in[30:0], ~trial[32]};
        end
    endgenerate

    assign step_acc = g_step[STEPS_PER_CYCLE-1].acc_out;
    assign step_qsh = g_step[STEPS_PER_CYCLE-1].qsh_out;

    always_ff @(posedge pos_clk or posedge pos_arst) begin
        if (pos_arst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            qsh_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            qsh_q   <= qsh_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        qsh_d   = qsh_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    acc_d = '0;
                    qsh_d = a;
                    dvs_d = b;
                    cnt_d = 6'(ITERS);
                    if (b == 32'd0) begin
                        state_d = ST_DONE;
                        quot_d  = 32'hFFFF_FFFF;
                        rem_d   = a;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                acc_d = step_acc;
                qsh_d = step_qsh;
                cnt_d = cnt_q - 6'd1;
                // Published results only move on entry to DONE, so they hold between operations.
                if (cnt_q == 6'd1) begin
                    state_d = ST_DONE;
                    quot_d  = step_qsh;
                    rem_d   = step_acc;
                    dbz_d   = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_v2f_seq_udiv32.sv
// Self-checking bench for v2f_seq_udiv32. It uses one instance per STEPS_PER_CYCLE value,
// directed vectors, hand-written corner sequences and a concurrent random sweep.
module tb_v2f_seq_udiv32;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] quot;
        logic [31:0] rem;
        logic        dbz;
    } vec_t;

    logic        clk;
    logic        pos_arst;
    logic        in_valid  [4];
    logic        in_ready  [4];
    logic [31:0] a_i       [4];
    logic [31:0] b_i       [4];
    logic        out_valid [4];
    logic        out_ready [4];
    logic [31:0] quot      [4];
    logic [31:0] rem       [4];
    logic        dbz       [4];

    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t sb_q[4][$];
    vec_t vecs[11];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            v2f_seq_udiv32 #(.STEPS_PER_CYCLE(1 << gi)) u_dut (
                .pos_clk     (clk),
                .pos_arst    (pos_arst),
                .in_valid    (in_valid[gi]),
                .in_ready    (in_ready[gi]),
                .a           (a_i[gi]),
                .b           (b_i[gi]),
                .out_valid   (out_valid[gi]),
                .out_ready   (out_ready[gi]),
                .quot        (quot[gi]),
                .rem         (rem[gi]),
                .div_by_zero (dbz[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // One full transaction on instance k with out_ready held high.
    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic ed);
        vec_t e;
        int   lat;
        int   exp_lat;
        logic [63:0] prod;
        exp_lat = (b == 32'd0) ? 1 : (32 / (1 << k)) + 1;
        @(negedge clk);
        chk("ready_before_op", 32'(in_ready[k]), 32'd1);
        a_i[k] = a;
        b_i[k] = b;
        in_valid[k] = 1'b1;
        e.a = a; e.b = b; e.quot = eq; e.rem = er; e.dbz = ed;
        @(posedge clk);
        sb_q[k].push_back(e);
        @(negedge clk);
        in_valid[k] = 1'b0;
        lat = 1;
        while (out_valid[k] !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        e = sb_q[k].pop_front();
        chk("quot", quot[k], e.quot);
        chk("rem", rem[k], e.rem);
        chk("div_by_zero", 32'(dbz[k]), 32'(e.dbz));
        if (e.b != 32'd0) begin
            prod = 64'(quot[k]) * 64'(e.b) + 64'(rem[k]);
            chk("identity", 32'(prod == 64'(e.a) && rem[k] < e.b), 32'd1);
        end
        $display("S=%0d a=%h b=%h -> quot=%h rem=%h dbz=%0d lat=%0d",
                 1 << k, a, b, quot[k], rem[k], dbz[k], lat);
        @(negedge clk);
        chk("out_valid_after_hs", 32'(out_valid[k]), 32'd0);
        chk("in_ready_after_hs", 32'(in_ready[k]), 32'd1);
    endtask

    task automatic sweep(input int k);
        logic [31:0] a, b, eq, er;
        logic        ed;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            case (i % 6)
                0: b = 32'd1;
                1: begin b = $urandom | 32'd1; a = a % b; end
                2: b = a;
                3: b = $urandom | 32'h8000_0000;
                4: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if (i == 7) b = 32'd0;
            if (b == 32'd0) begin
                eq = 32'hFFFF_FFFF; er = a; ed = 1'b1;
            end else begin
                eq = a / b; er = a % b; ed = 1'b0;
            end
            run_op(k, a, b, eq, er, ed);
        end
    endtask

    initial begin
        int  lat;
        bit  seen;
        vec_t e;
        pos_arst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b1; a_i[k] = '0; b_i[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready[0]), 32'd1);
        chk("reset_out_valid", 32'(out_valid[0]), 32'd0);
        chk("reset_quot", quot[0], 32'd0);
        chk("reset_rem", rem[0], 32'd0);
        chk("reset_dbz", 32'(dbz[0]), 32'd0);
        pos_arst = 1'b0;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0};
        vecs[2]  = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,          1'b0};
        vecs[3]  = '{32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
        vecs[4]  = '{32'd50,         32'd5,          32'd10,         32'd0,          1'b0};
        vecs[5]  = '{32'd9,          32'd4,          32'd2,          32'd1,          1'b0};
        vecs[6]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
        vecs[7]  = '{32'd7,          32'd7,          32'd1,          32'd0,          1'b0};
        vecs[8]  = '{32'd5,          32'd9,          32'd0,          32'd5,          1'b0};
        vecs[9]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[10] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
        for (int i = 0; i < 11; i++) begin
            run_op(0, vecs[i].a, vecs[i].b, vecs[i].quot, vecs[i].rem, vecs[i].dbz);
        end

        // Backpressure: result must hold and in_valid pulses must be ignored.
        @(negedge clk);
        out_ready[0] = 1'b0;
        a_i[0] = 32'd50; b_i[0] = 32'd5; in_valid[0] = 1'b1;
        e.a = 32'd50; e.b = 32'd5; e.quot = 32'd10; e.rem = 32'd0; e.dbz = 1'b0;
        @(posedge clk);
        sb_q[0].push_back(e);
        @(negedge clk);
        in_valid[0] = 1'b0;
        lat = 1;
        while (out_valid[0] !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_latency", 32'(lat), 32'd33);
        e = sb_q[0].pop_front();
        for (int i = 0; i < 10; i++) begin
            chk("bp_quot_hold", quot[0], e.quot);
            chk("bp_rem_hold", rem[0], e.rem);
            chk("bp_out_valid_hold", 32'(out_valid[0]), 32'd1);
            chk("bp_in_ready_low", 32'(in_ready[0]), 32'd0);
            if (i >= 2 && i <= 4) begin
                a_i[0] = 32'd9; b_i[0] = 32'd3; in_valid[0] = 1'b1;
            end else begin
                in_valid[0] = 1'b0;
            end
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        chk("bp_quot_final", quot[0], e.quot);
        $display("S=1 a=%h b=%h -> quot=%h rem=%h dbz=%0d (backpressure)",
                 e.a, e.b, quot[0], rem[0], dbz[0]);
        @(negedge clk);
        chk("bp_out_valid_drop", 32'(out_valid[0]), 32'd0);
        chk("bp_in_ready_back", 32'(in_ready[0]), 32'd1);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid[0] === 1'b1) seen = 1'b1;
        end
        chk("bp_single_handshake", 32'(seen), 32'd0);
        chk("bp_quot_retained", quot[0], 32'd10);

        // Reset ten cycles into BUSY discards the operation.
        @(negedge clk);
        a_i[0] = 32'd1000; b_i[0] = 32'd3; in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_busy_in_ready", 32'(in_ready[0]), 32'd0);
        pos_arst = 1'b1;
        #1;
        chk("arst_quot", quot[0], 32'd0);
        chk("arst_rem", rem[0], 32'd0);
        chk("arst_in_ready", 32'(in_ready[0]), 32'd1);
        chk("arst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("arst_dbz", 32'(dbz[0]), 32'd0);
        @(negedge clk);
        pos_arst = 1'b0;
        $display("S=1 a=%h b=%h -> discarded by reset", 32'd1000, 32'd3);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid[0] === 1'b1) seen = 1'b1;
        end
        chk("arst_no_out_valid", 32'(seen), 32'd0);
        run_op(0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);

        fork
            sweep(0);
            sweep(1);
            sweep(2);
            sweep(3);
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
